// File: rtl/decode_pipe_if.sv
// Bus between the PIPE decode stage (decode_pipe) and the surrounding pipeline.
// Carries the decode inputs, the E/M/W forwarding and writeback buses, the stall/bubble controls, and the D->E register outputs.
interface decode_pipe_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic [3:0]        in_code;
  logic [3:0]        in_fun;
  logic [3:0]        ra;
  logic [3:0]        rb;
  logic [DATA_W-1:0] in_valc;
  logic [DATA_W-1:0] in_valp;
  logic              stall;
  logic              bubble;
  logic [3:0]        e_dst_e;
  logic [DATA_W-1:0] e_val_e;
  logic [3:0]        e_dst_m;
  logic [3:0]        m_dst_e;
  logic [DATA_W-1:0] m_val_e;
  logic [3:0]        m_dst_m;
  logic [DATA_W-1:0] val_m;
  logic [3:0]        w_dst_e;
  logic [DATA_W-1:0] w_val_e;
  logic [3:0]        w_dst_m;
  logic [DATA_W-1:0] w_val_m;
  logic              out_valid;
  logic [3:0]        out_code;
  logic [3:0]        out_fun;
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;
  logic [DATA_W-1:0] out_valc;
  logic [3:0]        out_dst_e;
  logic [3:0]        out_dst_m;
  logic [3:0]        out_src_a;
  logic [3:0]        out_src_b;
  logic              load_use;

  modport master (
    output in_valid, in_code, in_fun, ra, rb, in_valc, in_valp, stall, bubble,
    output e_dst_e, e_val_e, e_dst_m, m_dst_e, m_val_e, m_dst_m, val_m,
    output w_dst_e, w_val_e, w_dst_m, w_val_m,
    input  out_valid, out_code, out_fun, val_a, val_b, out_valc,
    input  out_dst_e, out_dst_m, out_src_a, out_src_b, load_use
  );

  modport slave (
    input  in_valid, in_code, in_fun, ra, rb, in_valc, in_valp, stall, bubble,
    input  e_dst_e, e_val_e, e_dst_m, m_dst_e, m_val_e, m_dst_m, val_m,
    input  w_dst_e, w_val_e, w_dst_m, w_val_m,
    output out_valid, out_code, out_fun, val_a, val_b, out_valc,
    output out_dst_e, out_dst_m, out_src_a, out_src_b, load_use
  );
endinterface

// File: rtl/decode_pipe.sv
// PIPE Y86-64 decode stage: register file, operand forwarding, D->E pipeline register, load/use hazard flag.
// Define DECODE_FWD_EN for full E/M/W forwarding; otherwise only W bypasses and every RAW hazard is flagged for stalling.
module decode_pipe #(
  parameter int DATA_W  = 64,
  parameter int NREGS   = 15,
  parameter int RSP_IDX = 4
) (
  input logic          clock,
  input logic          reset_n,
  decode_pipe_if.slave bus
);

  localparam logic [3:0] NONE = 4'hF;
  localparam logic [3:0] RSP  = 4'(RSP_IDX);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef struct packed {
    logic              valid;
    logic [3:0]        code;
    logic [3:0]        fun;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [DATA_W-1:0] valc;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
  } de_t;

  localparam de_t DE_NOP = '{
    valid: 1'b0,
    code:  I_NOP,
    fun:   4'h0,
    val_a: '0,
    val_b: '0,
    valc:  '0,
    dst_e: NONE,
    dst_m: NONE,
    src_a: NONE,
    src_b: NONE
  };

  logic [DATA_W-1:0] rf [NREGS];
  logic [3:0]        src_a;
  logic [3:0]        src_b;
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  de_t               de_d;
  de_t               de_q;

  // Register file; the M port is applied last so it wins a same-index write (popq %rsp).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rf <= '{default: '0};
    end else begin
      if (bus.w_dst_e != NONE && 32'(bus.w_dst_e) < NREGS && bus.w_dst_e != bus.w_dst_m)
        rf[bus.w_dst_e] <= bus.w_val_e;
      if (bus.w_dst_m != NONE && 32'(bus.w_dst_m) < NREGS)
        rf[bus.w_dst_m] <= bus.w_val_m;
    end
  end

  function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] idx);
    if (idx == NONE || 32'(idx) >= NREGS)
      return '0;
    return rf[idx];
  endfunction

  function automatic logic [DATA_W-1:0] operand(input logic [3:0] src);
    logic [DATA_W-1:0] v;
    if (src == NONE)
      v = '0;
`ifdef DECODE_FWD_EN
    else if (src == bus.e_dst_e)
      v = bus.e_val_e;
    else if (src == bus.m_dst_m)
      v = bus.val_m;
    else if (src == bus.m_dst_e)
      v = bus.m_val_e;
`endif
    else if (src == bus.w_dst_m)
      v = bus.w_val_m;
    else if (src == bus.w_dst_e)
      v = bus.w_val_e;
    else
      v = rf_read(src);
    return v;
  endfunction

  function automatic logic raw_hit(input logic [3:0] src);
`ifdef DECODE_FWD_EN
    return src != NONE && src == bus.e_dst_m;
`else
    return src != NONE &&
           (src == bus.e_dst_e || src == bus.e_dst_m ||
            src == bus.m_dst_e || src == bus.m_dst_m);
`endif
  endfunction

`ifndef DECODE_FWD_EN
  logic unused_fwd_vals;
  assign unused_fwd_vals = ^{bus.e_val_e, bus.m_val_e, bus.val_m};
`endif

  always_comb begin
    src_a = NONE;
    src_b = NONE;
    dst_e = NONE;
    dst_m = NONE;
    case (bus.in_code)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = bus.ra;
      I_RET, I_POPQ:                     src_a = RSP;
      default:                           src_a = NONE;
    endcase
    case (bus.in_code)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:         src_b = bus.rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    src_b = RSP;
      default:                           src_b = NONE;
    endcase
    // cmovXX keeps dstE here; execute cancels it when the condition fails.
    case (bus.in_code)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:         dst_e = bus.rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    dst_e = RSP;
      default:                           dst_e = NONE;
    endcase
    case (bus.in_code)
      I_MRMOVQ, I_POPQ:                  dst_m = bus.ra;
      default:                           dst_m = NONE;
    endcase
  end

  always_comb begin
    de_d       = DE_NOP;
    de_d.valid = bus.in_valid;
    de_d.code  = bus.in_code;
    de_d.fun   = bus.in_fun;
    de_d.val_a = (bus.in_code == I_JXX || bus.in_code == I_CALL) ? bus.in_valp : operand(src_a);
    de_d.val_b = operand(src_b);
    de_d.valc  = bus.in_valc;
    de_d.dst_e = dst_e;
    de_d.dst_m = dst_m;
    de_d.src_a = src_a;
    de_d.src_b = src_b;
  end

  assign bus.load_use = bus.in_valid && (raw_hit(src_a) || raw_hit(src_b));

  // Stall outranks bubble: a stalled register must keep its instruction.
  always_ff @(posedge clock) begin
    if (!reset_n)
      de_q <= DE_NOP;
    else if (!bus.stall)
      de_q <= bus.bubble ? DE_NOP : de_d;
  end

  assign bus.out_valid = de_q.valid;
  assign bus.out_code  = de_q.code;
  assign bus.out_fun   = de_q.fun;
  assign bus.val_a     = de_q.val_a;
  assign bus.val_b     = de_q.val_b;
  assign bus.out_valc  = de_q.valc;
  assign bus.out_dst_e = de_q.dst_e;
  assign bus.out_dst_m = de_q.dst_m;
  assign bus.out_src_a = de_q.src_a;
  assign bus.out_src_b = de_q.src_b;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed test-plan steps followed by random cycles against a behavioural model.
module tb_decode_pipe;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  decode_pipe_if #(.DATA_W(64)) bus ();

  decode_pipe #(.DATA_W(64), .NREGS(15), .RSP_IDX(4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  logic [63:0] mrf [16];
  logic        x_valid;
  logic [3:0]  x_code, x_fun, x_dst_e, x_dst_m, x_src_a, x_src_b;
  logic [63:0] x_val_a, x_val_b, x_valc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_src_a(input logic [3:0] c, input logic [3:0] r);
    if (c inside {4'h2, 4'h4, 4'h6, 4'hA}) return r;
    if (c inside {4'h9, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] c, input logic [3:0] r);
    if (c inside {4'h4, 4'h5, 4'h6}) return r;
    if (c inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] c, input logic [3:0] r);
    if (c inside {4'h2, 4'h3, 4'h6}) return r;
    if (c inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] c, input logic [3:0] r);
    return (c inside {4'h5, 4'hB}) ? r : 4'hF;
  endfunction

  // Forwarding sources as an ordered list; the first producer naming the register supplies it.
  function automatic logic [63:0] m_operand(input logic [3:0] s);
    logic [3:0]  d [$];
    logic [63:0] v [$];
    if (s == 4'hF) return 64'h0;
`ifdef DECODE_FWD_EN
    d.push_back(bus.e_dst_e); v.push_back(bus.e_val_e);
    d.push_back(bus.m_dst_m); v.push_back(bus.val_m);
    d.push_back(bus.m_dst_e); v.push_back(bus.m_val_e);
`endif
    d.push_back(bus.w_dst_m); v.push_back(bus.w_val_m);
    d.push_back(bus.w_dst_e); v.push_back(bus.w_val_e);
    foreach (d[i]) if (d[i] == s) return v[i];
    return (s < 4'd15) ? mrf[s] : 64'h0;
  endfunction

  function automatic logic m_load_use();
    logic [3:0] srcs [2];
    logic [3:0] haz [$];
    srcs[0] = m_src_a(bus.in_code, bus.ra);
    srcs[1] = m_src_b(bus.in_code, bus.rb);
    haz.push_back(bus.e_dst_m);
`ifndef DECODE_FWD_EN
    haz.push_back(bus.e_dst_e);
    haz.push_back(bus.m_dst_e);
    haz.push_back(bus.m_dst_m);
`endif
    if (!bus.in_valid) return 1'b0;
    foreach (srcs[i])
      foreach (haz[j])
        if (srcs[i] != 4'hF && srcs[i] == haz[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_code = 4'h1; bus.in_fun = 4'h0;
    bus.ra = 4'hF; bus.rb = 4'hF; bus.in_valc = '0; bus.in_valp = '0;
    bus.stall = 1'b0; bus.bubble = 1'b0;
    bus.e_dst_e = 4'hF; bus.e_val_e = '0; bus.e_dst_m = 4'hF;
    bus.m_dst_e = 4'hF; bus.m_val_e = '0; bus.m_dst_m = 4'hF; bus.val_m = '0;
    bus.w_dst_e = 4'hF; bus.w_val_e = '0; bus.w_dst_m = 4'hF; bus.w_val_m = '0;
  endtask

  task automatic decode(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b);
    bus.in_valid = 1'b1; bus.in_code = c; bus.ra = a; bus.rb = b;
  endtask

  // One clock: check load_use, predict the D->E register, clock, update the model RF, compare.
  task automatic cycle();
    logic        n_valid;
    logic [3:0]  n_code, n_fun, n_de, n_dm, n_sa, n_sb;
    logic [63:0] n_a, n_b, n_c;
    logic [3:0]  wde, wdm;
    logic [63:0] wve, wvm;
    logic        rst;
    #1;
    chk("load_use", {63'h0, bus.load_use}, {63'h0, m_load_use()});
    rst = !reset_n;
    if (rst || (!bus.stall && bus.bubble)) begin
      n_valid = 0; n_code = 4'h1; n_fun = 0; n_a = 0; n_b = 0; n_c = 0;
      n_de = 4'hF; n_dm = 4'hF; n_sa = 4'hF; n_sb = 4'hF;
    end else if (bus.stall) begin
      n_valid = x_valid; n_code = x_code; n_fun = x_fun; n_a = x_val_a; n_b = x_val_b;
      n_c = x_valc; n_de = x_dst_e; n_dm = x_dst_m; n_sa = x_src_a; n_sb = x_src_b;
    end else begin
      n_valid = bus.in_valid; n_code = bus.in_code; n_fun = bus.in_fun; n_c = bus.in_valc;
      n_sa = m_src_a(bus.in_code, bus.ra);
      n_sb = m_src_b(bus.in_code, bus.rb);
      n_de = m_dst_e(bus.in_code, bus.rb);
      n_dm = m_dst_m(bus.in_code, bus.ra);
      n_a  = (bus.in_code inside {4'h7, 4'h8}) ? bus.in_valp : m_operand(n_sa);
      n_b  = m_operand(n_sb);
    end
    wde = bus.w_dst_e; wve = bus.w_val_e; wdm = bus.w_dst_m; wvm = bus.w_val_m;
    @(posedge clock);
    #1;
    if (rst) begin
      foreach (mrf[i]) mrf[i] = 64'h0;
    end else begin
      if (wde < 4'd15) mrf[wde] = wve;
      if (wdm < 4'd15) mrf[wdm] = wvm;
    end
    x_valid = n_valid; x_code = n_code; x_fun = n_fun; x_val_a = n_a; x_val_b = n_b;
    x_valc = n_c; x_dst_e = n_de; x_dst_m = n_dm; x_src_a = n_sa; x_src_b = n_sb;
    chk("out_valid", {63'h0, bus.out_valid}, {63'h0, x_valid});
    chk("out_code",  {60'h0, bus.out_code},  {60'h0, x_code});
    chk("out_fun",   {60'h0, bus.out_fun},   {60'h0, x_fun});
    chk("val_a",     bus.val_a,              x_val_a);
    chk("val_b",     bus.val_b,              x_val_b);
    chk("out_valc",  bus.out_valc,           x_valc);
    chk("out_dst_e", {60'h0, bus.out_dst_e}, {60'h0, x_dst_e});
    chk("out_dst_m", {60'h0, bus.out_dst_m}, {60'h0, x_dst_m});
    chk("out_src_a", {60'h0, bus.out_src_a}, {60'h0, x_src_a});
    chk("out_src_b", {60'h0, bus.out_src_b}, {60'h0, x_src_b});
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    foreach (mrf[i]) mrf[i] = 64'h0;
    x_valid = 0; x_code = 4'h1; x_fun = 0; x_val_a = 0; x_val_b = 0; x_valc = 0;
    x_dst_e = 4'hF; x_dst_m = 4'hF; x_src_a = 4'hF; x_src_b = 4'hF;

    reset_n = 1'b0;
    idle();
    cycle();
    cycle();
    chk("rst_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("rst_code",  {60'h0, bus.out_code},  64'h1);
    chk("rst_dst_e", {60'h0, bus.out_dst_e}, 64'hF);
    chk("rst_val_a", bus.val_a, 64'h0);
    chk("rst_val_b", bus.val_b, 64'h0);
    reset_n = 1'b1;

    bus.w_dst_e = 4'd3; bus.w_val_e = 64'h10;
    cycle();
    idle(); decode(4'h6, 4'd3, 4'd3);
    cycle();
    chk("wb_val_a", bus.val_a, 64'h10);
    chk("wb_val_b", bus.val_b, 64'h10);

    idle(); decode(4'h6, 4'd3, 4'd3);
    bus.e_dst_e = 4'd3; bus.e_val_e = 64'h20; bus.m_dst_m = 4'd3; bus.val_m = 64'h30;
    cycle();
`ifdef DECODE_FWD_EN
    chk("fwd_prio", bus.val_a, 64'h20);
`else
    chk("fwd_prio", bus.val_a, 64'h10);
`endif

    idle(); decode(4'h6, 4'd7, 4'd3); bus.e_dst_m = 4'd7;
    #1 chk("lu_flag", {63'h0, bus.load_use}, 64'h1);
    cycle();
    idle(); bus.bubble = 1'b1;
    cycle();
    chk("bubble_code",  {60'h0, bus.out_code},  64'h1);
    chk("bubble_valid", {63'h0, bus.out_valid}, 64'h0);

    idle(); bus.w_dst_e = 4'd4; bus.w_val_e = 64'h100;
    cycle();
    idle(); decode(4'hB, 4'd4, 4'hF);
    cycle();
    chk("popq_src_a", {60'h0, bus.out_src_a}, 64'h4);
    chk("popq_src_b", {60'h0, bus.out_src_b}, 64'h4);
    chk("popq_dst_e", {60'h0, bus.out_dst_e}, 64'h4);
    chk("popq_dst_m", {60'h0, bus.out_dst_m}, 64'h4);
    chk("popq_val_b", bus.val_b, 64'h100);
    idle(); bus.w_dst_e = 4'd4; bus.w_val_e = 64'h108; bus.w_dst_m = 4'd4; bus.w_val_m = 64'hAB;
    cycle();
    idle(); decode(4'h2, 4'd4, 4'd5);
    cycle();
    chk("popq_rsp", bus.val_a, 64'hAB);

    idle(); decode(4'h6, 4'd1, 4'd2); bus.in_valc = 64'h55;
    cycle();
    idle(); decode(4'h3, 4'd5, 4'd6); bus.in_valc = 64'h77; bus.stall = 1'b1; bus.bubble = 1'b1;
    cycle();
    bus.in_code = 4'hA; bus.in_valc = 64'h99;
    cycle();
    chk("stall_code", {60'h0, bus.out_code}, 64'h6);
    chk("stall_valc", bus.out_valc, 64'h55);
    chk("stall_valid", {63'h0, bus.out_valid}, 64'h1);
    idle(); decode(4'h8, 4'hF, 4'hF); bus.in_valp = 64'h1234;
    cycle();
    chk("call_val_a", bus.val_a, 64'h1234);
    chk("call_dst_e", {60'h0, bus.out_dst_e}, 64'h4);

    for (int n = 0; n < 400; n++) begin
      reset_n      = ($urandom_range(0, 49) != 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_code  = 4'($urandom_range(0, 15));
      bus.in_fun   = 4'($urandom_range(0, 15));
      bus.ra       = 4'($urandom_range(0, 15));
      bus.rb       = 4'($urandom_range(0, 15));
      bus.in_valc  = {$urandom, $urandom};
      bus.in_valp  = {$urandom, $urandom};
      bus.stall    = ($urandom_range(0, 7) == 0);
      bus.bubble   = ($urandom_range(0, 7) == 0);
      bus.e_dst_e  = rnd_reg(); bus.e_val_e = {$urandom, $urandom};
      bus.e_dst_m  = rnd_reg();
      bus.m_dst_e  = rnd_reg(); bus.m_val_e = {$urandom, $urandom};
      bus.m_dst_m  = rnd_reg(); bus.val_m   = {$urandom, $urandom};
      bus.w_dst_e  = rnd_reg(); bus.w_val_e = {$urandom, $urandom};
      bus.w_dst_m  = rnd_reg(); bus.w_val_m = {$urandom, $urandom};
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
